wrr_burst_arbiter: RTL and testbench

//  Shares one downstream valid/ready port among NUM_REQ upstream requesters.

---
 rtl/wrr_burst_arbiter.sv | 134 +++++++++++++
 tb/tb_wrr_burst_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wrr_burst_arbiter.sv
// Packet-aware weighted round-robin arbiter: one owner per turn,
// whole bursts only, up to weight[i] bursts per turn.
module wrr_burst_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 32,
  parameter int WEIGHT_W = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*WEIGHT_W-1:0]  weight,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  base_q, base_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic                at_bnd_q, at_bnd_d;
  logic                busy_q, busy_d;

  logic [IDX_W-1:0]    base_idx;
  logic [IDX_W-1:0]    pick_idx;
  logic [NUM_REQ-1:0]  pick_oh;
  logic [WEIGHT_W-1:0] pick_w;
  logic                beat;
  logic                own_valid;

  // Zero-cycle datapath through the current owner.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) out_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign own_valid = |(req_valid & grant_q);
  assign out_valid = own_valid;
  assign out_last  = |(req_last & grant_q);
  assign req_ready = grant_q & {NUM_REQ{out_ready}};
  assign beat      = out_valid & out_ready;
  assign grant     = grant_q;
  assign busy      = busy_q;

  // Circular search for the first valid requester at or above base.
  always_comb begin
    int idx;
    logic found;
    base_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (base_q[i]) base_idx = IDX_W'(i);
    end
    pick_oh  = '0;
    pick_idx = '0;
    found    = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(base_idx) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        pick_oh[idx] = 1'b1;
        pick_idx     = IDX_W'(idx);
        found        = 1'b1;
      end
    end
    pick_w = weight[pick_idx*WEIGHT_W +: WEIGHT_W];
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    base_d   = base_q;
    credit_d = credit_q;
    at_bnd_d = at_bnd_q;
    busy_d   = busy_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          state_d  = S_GRANT;
          grant_d  = pick_oh;
          credit_d = (pick_w == '0) ? WEIGHT_W'(1) : pick_w;
          at_bnd_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      S_GRANT: begin
        if (beat) at_bnd_d = out_last;
        if ((beat && out_last && credit_q == WEIGHT_W'(1)) ||
            (!beat && at_bnd_q && !own_valid)) begin
          state_d = S_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          base_d  = {grant_q[NUM_REQ-2:0], grant_q[NUM_REQ-1]};
        end else if (beat && out_last) begin
          credit_d = credit_q - WEIGHT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      base_q   <= NUM_REQ'(1);
      credit_q <= '0;
      at_bnd_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      base_q   <= base_d;
      credit_q <= credit_d;
      at_bnd_q <= at_bnd_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Bench for wrr_burst_arbiter: directed scenarios plus randomized
// traffic against a turn-based reference model.
module tb_wrr_burst_arbiter;

  logic         clk = 1'b0;
  logic         rstn;
  logic [3:0]   vld;
  logic [3:0]   lst;
  logic [127:0] data;
  logic [3:0]   req_ready;
  logic [15:0]  wgt;
  logic         out_valid;
  logic [31:0]  out_data;
  logic         out_last;
  logic         rdy;
  logic [3:0]   grant;
  logic         busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  wrr_burst_arbiter #(
    .NUM_REQ(4),
    .DATA_W(32),
    .WEIGHT_W(4)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .req_valid(vld),
    .req_last(lst),
    .req_data(data),
    .req_ready(req_ready),
    .weight(wgt),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_last(out_last),
    .out_ready(rdy),
    .grant(grant),
    .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    vld  = '0;
    lst  = '0;
    rdy  = 1'b1;
    wgt  = 16'h1111;
    data = {$urandom, $urandom, $urandom, $urandom};
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    vld  = 4'hF;
    lst  = 4'hF;
    rdy  = 1'b1;
    wgt  = 16'h1111;
    data = '0;
    repeat (3) step();
    #1;
    n_chk++;
    if (grant !== 4'b0000)
      $display("FAIL reset_grant got=%b exp=0000", grant);
    else n_pass++;
    n_chk++;
    if (req_ready !== 4'b0000)
      $display("FAIL reset_ready got=%b exp=0000", req_ready);
    else n_pass++;
    n_chk++;
    if (out_valid !== 1'b0)
      $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0)
      $display("FAIL reset_busy got=%b exp=0", busy);
    else n_pass++;
    rstn = 1'b1;
    step();
    n_chk++;
    if (grant !== 4'b0001)
      $display("FAIL reset_first_grant got=%b exp=0001", grant);
    else n_pass++;
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g [9];
    exp_g = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
    do_reset();
    vld = 4'hF;
    lst = 4'hF;
    for (int i = 0; i < 9; i++) begin
      step();
      n_chk++;
      if (grant !== exp_g[i])
        $display("FAIL rotation[%0d] got=%b exp=%b", i, grant, exp_g[i]);
      else n_pass++;
    end
  endtask

  task automatic test_weight();
    int         seq[$];
    logic [3:0] cnt;
    logic [3:0] acc;
    int         exp_s [9];
    exp_s = '{1, 1, 1, 1, 1, 1, 2, 2, 1};
    do_reset();
    wgt = 16'h0130;
    vld = 4'b0110;
    cnt = '0;
    for (int c = 0; c < 40 && seq.size() < 9; c++) begin
      lst = cnt;
      #1;
      acc = req_ready & vld;
      for (int i = 0; i < 4; i++) if (acc[i]) seq.push_back(i);
      step();
      cnt = cnt ^ acc;
    end
    n_chk++;
    if (seq.size() < 9)
      $display("FAIL weight_timeout got=%0d beats exp=9", seq.size());
    else n_pass++;
    for (int i = 0; i < 9 && i < seq.size(); i++) begin
      n_chk++;
      if (seq[i] !== exp_s[i])
        $display("FAIL weight_beat[%0d] got=%0d exp=%0d", i, seq[i], exp_s[i]);
      else n_pass++;
    end
  endtask

  task automatic test_burst_lock();
    do_reset();
    vld = 4'b1001;
    lst = 4'b0000;
    step();
    n_chk++;
    if (grant !== 4'b0001 || out_valid !== 1'b1)
      $display("FAIL lock_start got=%b/%b exp=0001/1", grant, out_valid);
    else n_pass++;
    step();
    vld = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_chk++;
      if (grant !== 4'b0001 || out_valid !== 1'b0)
        $display("FAIL lock_gap[%0d] got=%b/%b exp=0001/0", i, grant, out_valid);
      else n_pass++;
      step();
    end
    vld = 4'b1001;
    lst = 4'b0001;
    #1;
    n_chk++;
    if (out_last !== 1'b1 || req_ready !== 4'b0001)
      $display("FAIL lock_end got=%b/%b exp=1/0001", out_last, req_ready);
    else n_pass++;
    step();
    vld = 4'b1000;
    #1;
    n_chk++;
    if (grant !== 4'b0000)
      $display("FAIL lock_dead got=%b exp=0000", grant);
    else n_pass++;
    step();
    n_chk++;
    if (grant !== 4'b1000)
      $display("FAIL lock_next got=%b exp=1000", grant);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    data[95:64] = 32'hA5A5_5A5A;
    wgt = 16'h0211;
    vld = 4'b0100;
    lst = 4'b0000;
    step();
    n_chk++;
    if (grant !== 4'b0100)
      $display("FAIL bp_grant got=%b exp=0100", grant);
    else n_pass++;
    step();
    rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_chk++;
      if (req_ready !== 4'b0000 || out_data !== 32'hA5A5_5A5A ||
          grant !== 4'b0100 || out_valid !== 1'b1)
        $display("FAIL bp_hold[%0d] got=%b/%h/%b exp=0000/a5a55a5a/0100",
                 i, req_ready, out_data, grant);
      else n_pass++;
      step();
    end
    rdy = 1'b1;
    lst = 4'b0100;
    step();
    n_chk++;
    if (grant !== 4'b0100 || busy !== 1'b1)
      $display("FAIL bp_credit got=%b/%b exp=0100/1", grant, busy);
    else n_pass++;
    step();
    n_chk++;
    if (grant !== 4'b0000)
      $display("FAIL bp_release got=%b exp=0000", grant);
    else n_pass++;
  endtask

  task automatic test_early_yield();
    do_reset();
    wgt = 16'h0000;
    vld = 4'b0100;
    lst = 4'b0100;
    step();
    n_chk++;
    if (grant !== 4'b0100)
      $display("FAIL w0_grant got=%b exp=0100", grant);
    else n_pass++;
    vld = 4'b0000;
    step();
    n_chk++;
    if (grant !== 4'b0000 || busy !== 1'b0)
      $display("FAIL w0_release got=%b/%b exp=0000/0", grant, busy);
    else n_pass++;
    wgt = 16'h0030;
    vld = 4'b0010;
    lst = 4'b0010;
    step();
    n_chk++;
    if (grant !== 4'b0010)
      $display("FAIL yield_grant got=%b exp=0010", grant);
    else n_pass++;
    step();
    vld = 4'b0000;
    #1;
    n_chk++;
    if (grant !== 4'b0010)
      $display("FAIL yield_hold got=%b exp=0010", grant);
    else n_pass++;
    step();
    n_chk++;
    if (grant !== 4'b0000)
      $display("FAIL yield_release got=%b exp=0000", grant);
    else n_pass++;
    vld = 4'b0001;
    lst = 4'b0000;
    step();
    step();
    n_chk++;
    if (grant !== 4'b0001)
      $display("FAIL abort_pre got=%b exp=0001", grant);
    else n_pass++;
    rstn = 1'b0;
    #1;
    n_chk++;
    if (grant !== 4'b0000 || busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL abort_async got=%b/%b/%b exp=0000/0/0",
               grant, busy, out_valid);
    else n_pass++;
    step();
    rstn = 1'b1;
  endtask

  task automatic test_random();
    int         m_owner;
    int         m_left;
    bit         m_mid;
    int         m_base;
    int         k;
    int         j;
    int         w;
    bit         f;
    logic [3:0] eg;
    do_reset();
    m_owner = -1;
    m_left  = 0;
    m_mid   = 1'b0;
    m_base  = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        vld[i] = ($urandom_range(0, 9) < 6);
        lst[i] = ($urandom_range(0, 9) < 4);
      end
      data = {$urandom, $urandom, $urandom, $urandom};
      rdy  = ($urandom_range(0, 9) < 8);
      if (c % 17 == 0) wgt = 16'($urandom);
      #1;
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      n_chk++;
      if (grant !== eg || busy !== (m_owner >= 0) || !$onehot0(grant))
        $display("FAIL rand_grant[%0d] got=%b/%b exp=%b/%b",
                 c, grant, busy, eg, m_owner >= 0);
      else n_pass++;
      n_chk++;
      if (req_ready !== (eg & {4{rdy}}))
        $display("FAIL rand_ready[%0d] got=%b exp=%b",
                 c, req_ready, eg & {4{rdy}});
      else n_pass++;
      n_chk++;
      if (out_valid !== (m_owner >= 0 && vld[m_owner]))
        $display("FAIL rand_out_valid[%0d] got=%b exp=%b",
                 c, out_valid, m_owner >= 0 && vld[m_owner]);
      else n_pass++;
      if (m_owner >= 0) begin
        n_chk++;
        if (out_data !== data[m_owner*32 +: 32] ||
            out_last !== lst[m_owner])
          $display("FAIL rand_data[%0d] got=%h/%b exp=%h/%b", c,
                   out_data, out_last, data[m_owner*32 +: 32], lst[m_owner]);
        else n_pass++;
      end
      if (m_owner < 0) begin
        f = 1'b0;
        for (int off = 0; off < 4; off++) begin
          j = (m_base + off) % 4;
          if (!f && vld[j]) begin
            f       = 1'b1;
            m_owner = j;
            w       = int'(wgt[j*4 +: 4]);
            m_left  = (w == 0) ? 1 : w;
            m_mid   = 1'b0;
          end
        end
      end else begin
        k = m_owner;
        if (vld[k] && rdy) begin
          if (lst[k]) begin
            m_left--;
            m_mid = 1'b0;
            if (m_left == 0) begin
              m_owner = -1;
              m_base  = (k + 1) % 4;
            end
          end else begin
            m_mid = 1'b1;
          end
        end else if (!m_mid && !vld[k]) begin
          m_owner = -1;
          m_base  = (k + 1) % 4;
        end
      end
      step();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    vld  = '0;
    lst  = '0;
    rdy  = 1'b1;
    wgt  = 16'h1111;
    data = '0;
    #1;
    test_reset();
    test_rotation();
    test_weight();
    test_burst_lock();
    test_backpressure();
    test_early_yield();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
